// File: rtl/riscv151_mmio_pkg.sv
// Shared definitions for the UART MMIO controller.
//   - Byte offsets inside the 0x8000_00xx I/O window.
//   - Bit positions inside the status word at UART_CTRL_OFF.
//   - TX holding-register state encoding.
//   - addr_hit(): word-aligned offset compare that ignores addr[1:0].
package riscv151_mmio_pkg;

    localparam logic [7:0] UART_CTRL_OFF = 8'h00;
    localparam logic [7:0] UART_RX_OFF   = 8'h04;
    localparam logic [7:0] UART_TX_OFF   = 8'h08;
    localparam logic [7:0] CYCLE_CNT_OFF = 8'h10;
    localparam logic [7:0] INSTR_CNT_OFF = 8'h14;
    localparam logic [7:0] CNT_RST_OFF   = 8'h18;

    localparam int unsigned STAT_TX_FREE_BIT  = 0;
    localparam int unsigned STAT_RX_AVAIL_BIT = 1;
    localparam int unsigned STAT_TX_DROP_BIT  = 2;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

    function automatic logic addr_hit(input logic [7:0] addr, input logic [7:0] off);
        return (addr & 8'hFC) == off;
    endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// Bus bundle between the CPU/UART side and uart_mmio_ctrl.
//   mmio_addr/re/we/wdata -> controller, mmio_rdata <- controller (CPU loads/stores)
//   inst_retire           -> controller (instruction retire strobe)
//   rx_data/rx_valid      -> controller, rx_ready <- controller (uart_receiver)
//   tx_data/tx_valid      <- controller, tx_ready -> controller (uart_transmitter)
// The "slave" modport is the controller's view; "master" is the environment's.
interface uart_mmio_ctrl_if;

    logic [7:0]  mmio_addr;
    logic        mmio_re;
    logic        mmio_we;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        inst_retire;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output mmio_addr, mmio_re, mmio_we, mmio_wdata, inst_retire,
        output rx_data, rx_valid, tx_ready,
        input  mmio_rdata, rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  mmio_addr, mmio_re, mmio_we, mmio_wdata, inst_retire,
        input  rx_data, rx_valid, tx_ready,
        output mmio_rdata, rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/mmio_rx_fifo.sv
// Synchronous byte FIFO buffering uart_receiver data for CPU loads.
//   clk_i, rst_ni     clock, asynchronous active-low reset (pointers only)
//   push_i, push_data_i  write request; ignored when full
//   pop_i             read request; ignored when empty
//   full_o, empty_o   occupancy flags
//   head_o            oldest entry (undefined content when empty)
// Pointers carry one extra MSB so full and empty are distinguishable;
// they wrap modulo 2*DEPTH. DEPTH must be a power of 2, >= 2.
module mmio_rx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-side MMIO controller for the UART receiver/transmitter pair.
//   clk   core clock
//   rst   asynchronous active-low reset
//   bus   uart_mmio_ctrl_if.slave: CPU load/store port, retire strobe,
//         RX valid/ready handshake, TX valid/ready handshake
// Offsets: 0x00 status (R, clears tx_drop), 0x04 RX data (R, pops),
//          0x08 TX data (W). Loads return data one cycle after mmio_re.
// Optional feature macro MMIO_COUNTERS_EN adds cycle/instruction counters:
//          0x10 cycle_cnt (R), 0x14 instr_cnt (R), 0x18 clear both (W).
module uart_mmio_ctrl
    import riscv151_mmio_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    uart_mmio_ctrl_if.slave bus
);

    logic        rd_ctrl, rd_rx, wr_tx;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic [31:0] rdata_q, rdata_d;
    tx_state_e   tx_state_q;
    logic [7:0]  tx_data_q;
    logic        tx_drop_q;
    logic        unused_wdata;

    assign rd_ctrl = bus.mmio_re && addr_hit(bus.mmio_addr, UART_CTRL_OFF);
    assign rd_rx   = bus.mmio_re && addr_hit(bus.mmio_addr, UART_RX_OFF);
    assign wr_tx   = bus.mmio_we && addr_hit(bus.mmio_addr, UART_TX_OFF);

    mmio_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (bus.rx_valid),
        .push_data_i (bus.rx_data),
        .pop_i       (rd_rx),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign bus.rx_ready   = !fifo_full;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = (tx_state_q == TX_HOLD);
    assign bus.mmio_rdata = rdata_q;

`ifdef MMIO_COUNTERS_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        cnt_clr;

    assign cnt_clr = bus.mmio_we && addr_hit(bus.mmio_addr, CNT_RST_OFF);

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = bus.inst_retire ? instr_cnt_q + 32'd1 : instr_cnt_q;
        if (cnt_clr) begin
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign unused_wdata = ^bus.mmio_wdata[31:8];
`else
    assign unused_wdata = ^{bus.mmio_wdata[31:8], bus.inst_retire};
`endif

    // Load data mux; every source is sampled before this cycle's update.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.mmio_re) begin
            rdata_d = '0;
            if (addr_hit(bus.mmio_addr, UART_CTRL_OFF)) begin
                rdata_d[STAT_TX_FREE_BIT]  = (tx_state_q == TX_IDLE);
                rdata_d[STAT_RX_AVAIL_BIT] = !fifo_empty;
                rdata_d[STAT_TX_DROP_BIT]  = tx_drop_q;
            end else if (addr_hit(bus.mmio_addr, UART_RX_OFF)) begin
                rdata_d[7:0] = fifo_empty ? 8'h00 : fifo_head;
            end
`ifdef MMIO_COUNTERS_EN
            else if (addr_hit(bus.mmio_addr, CYCLE_CNT_OFF)) begin
                rdata_d = cycle_cnt_q;
            end else if (addr_hit(bus.mmio_addr, INSTR_CNT_OFF)) begin
                rdata_d = instr_cnt_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    // TX holding register FSM. The drop-set assignment comes after the
    // status-read clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
            tx_drop_q  <= 1'b0;
        end else begin
            if (rd_ctrl) tx_drop_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (wr_tx) begin
                        tx_data_q  <= bus.mmio_wdata[7:0];
                        tx_state_q <= TX_HOLD;
                    end
                end
                TX_HOLD: begin
                    if (wr_tx)        tx_drop_q  <= 1'b1;
                    if (bus.tx_ready) tx_state_q <= TX_IDLE;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

endmodule
